// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg -- shared types for the VRAM arbiter.
//   cpu_state_e : CPU handshake FSM states (IDLE, ACK).
//   gnt_src_e   : which requester owns the memory port in the current cycle.
package vram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } cpu_state_e;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_VGA   = 2'd1,
    GNT_DRAIN = 2'd2,
    GNT_CPU   = 2'd3
  } gnt_src_e;

endpackage

// File: rtl/vram_wbuf.sv
// vram_wbuf -- one-entry posted write buffer for the VRAM arbiter.
// Only instantiated when VRAM_ARBITER_WBUF_EN is defined.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (clears valid)
//   i_load            : capture i_addr/i_data, mark entry valid
//   i_drain           : entry written to memory this cycle, mark empty
//   i_addr, i_data    : CPU write address / data to capture
//   o_valid           : entry holds an undrained write
//   o_addr, o_data    : buffered write address / data
module vram_wbuf #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_drain,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  logic          r_vld_p1;
  logic [AW-1:0] r_addr_p1;
  logic [DW-1:0] r_data_p1;

  // Load only happens while empty, so load and drain never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
    end else if (i_load) begin
      r_vld_p1 <= 1'b1;
    end else if (i_drain) begin
      r_vld_p1 <= 1'b0;
    end
  end

  // Payload is qualified by r_vld_p1, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_addr_p1 <= i_addr;
      r_data_p1 <= i_data;
    end
  end

  assign o_valid = r_vld_p1;
  assign o_addr  = r_addr_p1;
  assign o_data  = r_data_p1;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter -- single-port screen-memory arbiter between VGA fetch and CPU.
// One memory operation per cycle, fixed priority VGA > buffer drain > CPU.
// Optional feature: define VRAM_ARBITER_WBUF_EN to add a one-entry posted
// write buffer (vram_wbuf); without it CPU writes go straight to memory.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   vga_req, vga_addr             : one-cycle VGA read request
//   vga_valid, vga_rdata          : VGA read data, one cycle after vga_req
//   cpu_req/we/addr/wdata         : CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata            : one-cycle completion pulse, read data
//   mem_addr/mem_we/mem_wdata     : memory command (combinational grant)
//   mem_rdata                     : memory read data, 1-cycle latency
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_valid,
  output logic [DW-1:0] vga_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  gnt_src_e      w_gnt;
  cpu_state_e    r_state;
  logic          r_vga_vld_p1;
  logic          r_cpu_ack_p1;
  logic          r_cpu_rd_p1;
  logic          w_buf_valid;
  logic [AW-1:0] w_buf_addr;
  logic [DW-1:0] w_buf_data;
  logic          w_buf_load;
  logic          w_cpu_go;

`ifdef VRAM_ARBITER_WBUF_EN
  // A CPU write is posted into the empty buffer without touching memory,
  // so VGA traffic cannot delay its acknowledge.
  assign w_buf_load = !reset && (r_state == IDLE) && cpu_req && cpu_we && !w_buf_valid;

  vram_wbuf #(
    .AW(AW),
    .DW(DW)
  ) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_buf_load),
    .i_drain (w_gnt == GNT_DRAIN),
    .i_addr  (cpu_addr),
    .i_data  (cpu_wdata),
    .o_valid (w_buf_valid),
    .o_addr  (w_buf_addr),
    .o_data  (w_buf_data)
  );
`else
  assign w_buf_load  = 1'b0;
  assign w_buf_valid = 1'b0;
  assign w_buf_addr  = '0;
  assign w_buf_data  = '0;
`endif

  // Stage 0: grant decision for the current cycle.
  // A full buffer blocks CPU reads (read-after-write ordering) and CPU
  // writes (no room) simply by outranking the CPU.
  always_comb begin
    w_gnt = GNT_NONE;
    if (!reset) begin
      if (vga_req) begin
        w_gnt = GNT_VGA;
      end else if (w_buf_valid) begin
        w_gnt = GNT_DRAIN;
      end else if ((r_state == IDLE) && cpu_req && !w_buf_load) begin
        w_gnt = GNT_CPU;
      end
    end
  end

  assign w_cpu_go = (w_gnt == GNT_CPU) || w_buf_load;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (w_gnt)
      GNT_VGA: begin
        mem_addr = vga_addr;
      end
      GNT_DRAIN: begin
        mem_addr  = w_buf_addr;
        mem_we    = 1'b1;
        mem_wdata = w_buf_data;
      end
      GNT_CPU: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
      end
      default: begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
      end
    endcase
  end

  // Stage 1: registered completion flags, aligned with mem_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cpu_ack_p1 <= 1'b0;
      r_cpu_rd_p1  <= 1'b0;
      r_vga_vld_p1 <= 1'b0;
    end else begin
      r_vga_vld_p1 <= (w_gnt == GNT_VGA);
      case (r_state)
        IDLE: begin
          if (w_cpu_go) begin
            r_state      <= ACK;
            r_cpu_ack_p1 <= 1'b1;
            r_cpu_rd_p1  <= !cpu_we;
          end else begin
            r_cpu_ack_p1 <= 1'b0;
          end
        end
        ACK: begin
          // cpu_req may still be high here; the next grant waits for IDLE.
          r_state      <= IDLE;
          r_cpu_ack_p1 <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_cpu_ack_p1 <= 1'b0;
        end
      endcase
    end
  end

  // Reset masks the pulses immediately so an in-flight op is aborted unacked.
  assign vga_valid = r_vga_vld_p1 && !reset;
  assign vga_rdata = vga_valid ? mem_rdata : '0;
  assign cpu_ack   = r_cpu_ack_p1 && !reset;
  assign cpu_rdata = (cpu_ack && r_cpu_rd_p1) ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter -- directed + randomized bench for vram_arbiter.
// Works in both builds; define VRAM_ARBITER_WBUF_EN to exercise the buffer.
module tb_vram_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
`ifdef VRAM_ARBITER_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif
  localparam int LAT_MAX = 3;

  logic          clk;
  logic          reset;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_valid;
  logic [DW-1:0] vga_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_valid (vga_valid),
    .vga_rdata (vga_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return {8'hA5, 12'(i), 12'(i * 7)};
  endfunction

  // Single-port synchronous memory attached to the arbiter.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] watch_addr = '0;
  int            wr_count = 0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(i);
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (mem_addr == watch_addr) wr_count <= wr_count + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Reference model: CPU-visible memory contents plus transaction bookkeeping.
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  int            checks = 0;
  int            errors = 0;
  bit            exp_vga_vld;
  logic [DW-1:0] exp_vga_data;
  logic [DW-1:0] last_vga_data;
  logic [DW-1:0] last_rdata;
  bit            cpu_out;
  bit            ack_seen;
  bit            timed_out;
  int            cpu_wait;
  int            last_lat;
  bit            cur_we;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    cur_we    = we;
    cur_addr  = a;
    cur_wdata = d;
    cpu_out   = 1'b1;
    cpu_wait  = 0;
  endtask

  // One clock cycle: inputs were set after the previous edge; outputs are
  // judged at the falling edge, then the cycle is closed.
  task automatic tick();
    @(negedge clk);
    ack_seen  = 1'b0;
    timed_out = 1'b0;
    if (reset) begin
      check("rst_vga_valid", DW'(vga_valid), '0);
      check("rst_cpu_ack", DW'(cpu_ack), '0);
      check("rst_mem_we", DW'(mem_we), '0);
      check("rst_vga_rdata", vga_rdata, '0);
      check("rst_cpu_rdata", cpu_rdata, '0);
      exp_vga_vld = 1'b0;
      cpu_out     = 1'b0;
    end else begin
      check("vga_valid", DW'(vga_valid), DW'(exp_vga_vld));
      if (exp_vga_vld) begin
        check("vga_rdata", vga_rdata, exp_vga_data);
        last_vga_data = vga_rdata;
      end
      exp_vga_vld = vga_req;
      if (vga_req) begin
        check("vga_gnt_we", DW'(mem_we), '0);
        check("vga_gnt_addr", DW'(mem_addr), DW'(vga_addr));
        exp_vga_data = model_mem[vga_addr];
      end
      if (cpu_ack) begin
        check("ack_expected", DW'(cpu_out), DW'(1));
        if (cpu_out) begin
          last_lat = cpu_wait;
          check("cpu_latency_ok", DW'(cpu_wait <= LAT_MAX), DW'(1));
          if (cur_we) begin
            model_mem[cur_addr] = cur_wdata;
          end else begin
            check("cpu_rdata", cpu_rdata, model_mem[cur_addr]);
            last_rdata = cpu_rdata;
          end
        end
        cpu_out  = 1'b0;
        ack_seen = 1'b1;
      end else if (cpu_out) begin
        cpu_wait++;
        if (cpu_wait > LAT_MAX) begin
          check("cpu_timeout", DW'(cpu_wait), DW'(LAT_MAX));
          cpu_out   = 1'b0;
          timed_out = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    vga_req = 1'b0;
    if (ack_seen || timed_out) cpu_req = 1'b0;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!cpu_out) break;
    end
  endtask

  initial begin
    int            base;
    int            vga_gap;
    logic [DW-1:0] old_val;
    logic [DW-1:0] exp_val;

    reset     = 1'b1;
    vga_req   = 1'b0;
    vga_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    exp_vga_vld = 1'b0;
    exp_vga_data = '0;
    last_vga_data = '0;
    last_rdata = '0;
    cpu_out = 1'b0;
    cpu_wait = 0;
    last_lat = 0;
    cur_we = 1'b0;
    cur_addr = '0;
    cur_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = pat(i);

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // VGA read of 0x010 (DEADBEEF), no CPU activity.
    vga_req  = 1'b1;
    vga_addr = 12'h010;
    tick();
    tick();
    check("req032_vga_data", last_vga_data, 32'hDEADBEEF);
    check("req032_no_ack", DW'(ack_seen), '0);
    tick();

    // CPU read colliding with VGA: VGA first, CPU acked two cycles later.
    vga_req  = 1'b1;
    vga_addr = 12'h811;
    start_cpu(1'b0, 12'h020, '0);
    wait_ack();
    check("req033_latency", DW'(last_lat), DW'(2));
    check("req033_rdata", last_rdata, pat(32));
    repeat (2) tick();

    // Write held through ACK: a single ack and a single memory write.
    watch_addr = 12'h024;
    base = wr_count;
    start_cpu(1'b1, 12'h024, 32'hCAFE0001);
    wait_ack();
    check("req034_latency", DW'(last_lat), DW'(1));
    repeat (3) tick();
    check("req034_one_write", DW'(wr_count - base), DW'(1));
    check("req034_mem", mem[12'h024], 32'hCAFE0001);

    // Write then read-back, write coinciding with VGA.
    vga_req  = 1'b1;
    vga_addr = 12'h812;
    start_cpu(1'b1, 12'h030, 32'h12345678);
    wait_ack();
    check("req035_wr_latency", DW'(last_lat), WBUF ? DW'(1) : DW'(2));
    start_cpu(1'b0, 12'h030, '0);
    wait_ack();
    check("req035_rdata", last_rdata, 32'h12345678);
    repeat (3) tick();

    // Reset while in ACK of a read; VGA request during reset is ignored.
    start_cpu(1'b0, 12'h022, '0);
    tick();
    reset    = 1'b1;
    cpu_req  = 1'b0;
    vga_req  = 1'b1;
    vga_addr = 12'h813;
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Reset with a write just accepted (buffered write must be discarded).
    watch_addr = 12'h040;
    base = wr_count;
    old_val = model_mem[12'h040];
    start_cpu(1'b1, 12'h040, 32'hBAD0BAD0);
    tick();
    reset   = 1'b1;
    cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    exp_val = WBUF ? old_val : 32'hBAD0BAD0;
    model_mem[12'h040] = exp_val;
    check("req036_mem", mem[12'h040], exp_val);
    check("req036_writes", DW'(wr_count - base), WBUF ? DW'(0) : DW'(1));

    // Random traffic: VGA at most every 4 cycles, back-to-back CPU ops.
    vga_gap = 0;
    for (int c = 0; c < 600; c++) begin
      if (vga_gap == 0) begin
        vga_req  = 1'b1;
        vga_addr = 12'h800 + 12'($urandom_range(0, 2047));
        vga_gap  = 3 + int'($urandom_range(0, 3));
      end else begin
        vga_gap--;
      end
      if (!cpu_req && ($urandom_range(0, 3) != 0)) begin
        start_cpu(1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), $urandom());
      end
      tick();
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 8 && cpu_out; i++) tick();
    repeat (4) tick();

    for (int a = 0; a < 128; a++) begin
      check("final_mem", mem[a], model_mem[a]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
